// File: rtl/downsampler_avg2x2_if.sv
// Pixel-stream bundle for the 2x2 box-average decimator: input strobe/data,
// decimated output strobe/data and the downstream FIFO full flag.
interface downsampler_avg2x2_if;
    logic       valid;
    logic [7:0] data;
    logic       fifo_full;
    logic [7:0] dataout;
    logic       validout;

    modport master (
        output valid,
        output data,
        output fifo_full,
        input  dataout,
        input  validout
    );

    modport slave (
        input  valid,
        input  data,
        input  fifo_full,
        output dataout,
        output validout
    );
endinterface

// File: rtl/downsampler_avg2x2.sv
// Streaming 2x2 box-average decimator, IMG_W x IMG_H in, half size out.
// Define DOWNSAMPLE_ROUND_EN for round-half-up averaging instead of truncation.
module downsampler_avg2x2 #(
    parameter int IMG_W = 800,
    parameter int IMG_H = 600,
    parameter int CW    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    downsampler_avg2x2_if.slave  s,
    output logic [CW-1:0]        current_rowcount,
    output logic [CW-1:0]        current_colcount,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

    logic [CW-1:0] col_reg, col_next;
    logic [CW-1:0] row_reg, row_next;
    logic [7:0]    h_reg;
    logic [7:0]    dataout_reg;
    logic          validout_reg;
    logic          frame_done_reg;
    logic          overflow_reg;

    // Horizontal pair sums of the most recent even row, one per output column.
    logic [8:0]    linebuf [LB_DEPTH];

    logic          col_last, row_last;
    logic          odd_col, odd_row;
    logic          lb_write, emit;
    logic [AW-1:0] lb_idx;
    logic [8:0]    pair;
    logic [9:0]    sum;
    logic [9:0]    sum_adj;
    logic [7:0]    result;

    assign col_last = (col_reg == COL_LAST);
    assign row_last = (row_reg == ROW_LAST);
    assign odd_col  = col_reg[0];
    assign odd_row  = row_reg[0];
    assign lb_idx   = col_reg[AW:1];
    assign lb_write = s.valid & odd_col & ~odd_row;
    assign emit     = s.valid & odd_col & odd_row;

    assign pair = 9'(h_reg) + 9'(s.data);
    assign sum  = 10'(linebuf[lb_idx]) + 10'(pair);

`ifdef DOWNSAMPLE_ROUND_EN
    // 1020 + 2 still fits in 10 bits, so the shifted value never exceeds 255.
    assign sum_adj = sum + 10'd2;
`else
    assign sum_adj = sum;
`endif
    assign result = 8'(sum_adj >> 2);

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (s.valid) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_reg        <= '0;
            row_reg        <= '0;
            h_reg          <= '0;
            dataout_reg    <= '0;
            validout_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            validout_reg   <= emit;
            frame_done_reg <= emit & col_last & row_last;
            // A write presented while the FIFO is full is lost; remember it until reset.
            overflow_reg   <= overflow_reg | (validout_reg & s.fifo_full);
            if (s.valid && !odd_col) begin
                h_reg <= s.data;
            end
            if (emit) begin
                dataout_reg <= result;
            end
        end
    end

    // Every entry is written on an even row before it is read, so no reset is needed.
    always_ff @(posedge clock) begin
        if (lb_write) begin
            linebuf[lb_idx] <= pair;
        end
    end

    assign s.dataout        = dataout_reg;
    assign s.validout       = validout_reg;
    assign current_rowcount = row_reg;
    assign current_colcount = col_reg;
    assign frame_done       = frame_done_reg;
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_downsampler_avg2x2.sv
// Directed bench for downsampler_avg2x2 on an 8x4 image; expectations are
// hand-derived block means (rounding chosen by DOWNSAMPLE_ROUND_EN).
module tb_downsampler_avg2x2;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int CWB = 4;
`ifdef DOWNSAMPLE_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    downsampler_avg2x2_if bus ();
    logic [CWB-1:0] rowc;
    logic [CWB-1:0] colc;
    logic           frame_done;
    logic           overflow;

    downsampler_avg2x2 #(.IMG_W(W), .IMG_H(H), .CW(CWB)) dut (
        .clock            (clock),
        .reset            (reset),
        .s                (bus),
        .current_rowcount (rowc),
        .current_colcount (colc),
        .frame_done       (frame_done),
        .overflow         (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] img [W*H];
    logic [7:0] out_q [$];
    int         fd_pos [$];

    // Capture every output pulse and the output index at which frame_done fires.
    always @(negedge clock) begin
        if (bus.validout === 1'b1) out_q.push_back(bus.dataout);
        if (frame_done === 1'b1) fd_pos.push_back(out_q.size() - 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clock);
        bus.valid = 1'b1;
        bus.data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.valid = 1'b0;
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < W*H; i++) begin
            send(img[i]);
            if (gaps) idle(1);
        end
        idle(3);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < W*H; i++) img[i] = 8'(i);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < W*H; i++) img[i] = v;
    endtask

    function automatic logic [31:0] ramp_mean(input int r, input int c);
        // Block holds 16r+2c, +1, +8, +9: mean is 16r+2c+4.5
        return 32'(16*r + 2*c + 4 + RND);
    endfunction

    initial begin
        bus.valid     = 1'b0;
        bus.data      = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_validout", 32'(bus.validout), 0);
        check("rst_dataout", 32'(bus.dataout), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_row", 32'(rowc), 0);
        check("rst_col", 32'(colc), 0);
        reset = 1'b1;

        // Constant 100, gapless frame
        fill_const(8'd100);
        out_q.delete(); fd_pos.delete();
        send_frame(1'b0);
        check("const_count", 32'(out_q.size()), 8);
        for (int i = 0; i < 8; i++) check($sformatf("const_out%0d", i), 32'(out_q[i]), 100);
        check("const_fd_count", 32'(fd_pos.size()), 1);
        check("const_fd_pos", 32'(fd_pos[0]), 7);
        check("const_row_wrap", 32'(rowc), 0);
        check("const_col_wrap", 32'(colc), 0);
        check("const_overflow", 32'(overflow), 0);

        // Single nonzero block {1,2},{3,4}: latency and rounding
        fill_const(8'd0);
        img[0] = 8'd1; img[1] = 8'd2; img[W] = 8'd3; img[W+1] = 8'd4;
        out_q.delete(); fd_pos.delete();
        for (int i = 0; i <= W; i++) send(img[i]);
        check("blk_no_early_valid", 32'(bus.validout), 0);
        send(img[W+1]);
        check("blk_latency_valid", 32'(bus.validout), 1);
        check("blk_first_out", 32'(bus.dataout), 32'((10 + 2*RND) >> 2));
        for (int i = W + 2; i < W*H; i++) send(img[i]);
        idle(3);
        check("blk_count", 32'(out_q.size()), 8);
        for (int i = 1; i < 8; i++) check($sformatf("blk_zero%0d", i), 32'(out_q[i]), 0);

        // Two back-to-back ramp frames with valid toggling every cycle
        fill_ramp();
        out_q.delete(); fd_pos.delete();
        send_frame(1'b1);
        send_frame(1'b1);
        check("ramp_count", 32'(out_q.size()), 16);
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 4; c++)
                    check($sformatf("ramp_f%0d_r%0d_c%0d", f, r, c),
                          32'(out_q[f*8 + r*4 + c]), ramp_mean(r, c));
        check("ramp_fd_count", 32'(fd_pos.size()), 2);
        check("ramp_fd_pos1", 32'(fd_pos[1]), 15);

        // Overflow: FIFO full during a frame, then sticky through a clean frame
        bus.fifo_full = 1'b1;
        send_frame(1'b0);
        bus.fifo_full = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        send_frame(1'b0);
        check("ovf_sticky", 32'(overflow), 1);

        // Reset asserted right after accepting row 3, col 5 with an output pulse live
        fill_ramp();
        for (int i = 0; i <= 3*W + 5; i++) send(img[i]);
        check("mid_validout_live", 32'(bus.validout), 1);
        check("mid_dataout_live", 32'(bus.dataout), ramp_mean(1, 2));
        check("mid_col", 32'(colc), 6);
        bus.valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_async_validout", 32'(bus.validout), 0);
        check("mid_async_dataout", 32'(bus.dataout), 0);
        check("mid_async_row", 32'(rowc), 0);
        check("mid_async_col", 32'(colc), 0);
        check("mid_async_overflow", 32'(overflow), 0);
        @(negedge clock);
        reset = 1'b1;
        out_q.delete(); fd_pos.delete();
        send_frame(1'b0);
        check("post_count", 32'(out_q.size()), 8);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                check($sformatf("post_r%0d_c%0d", r, c), 32'(out_q[r*4 + c]), ramp_mean(r, c));
        check("post_fd_count", 32'(fd_pos.size()), 1);
        check("post_fd_pos", 32'(fd_pos[0]), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
